// File: rtl/combo_sweep_ctrl.sv
// Self-test sequencer: sweeps the 4-input combo block through all 16 input
// vectors, captures its truth table and compares it against a golden table.
module combo_sweep_ctrl #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [15:0] EXPECTED = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        o,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic        mismatch,
    output logic [3:0]  first_fail
);

    localparam int unsigned IDX_W   = 4;
    localparam int unsigned TBL_W   = 16;
    localparam int unsigned CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TBL_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   vec_q, vec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [TBL_W-1:0]   table_q, table_d;
    logic               mismatch_q, mismatch_d;
    logic [IDX_W-1:0]   first_fail_q, first_fail_d;

    // State register; every output is a flop loaded with its next-state value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            table_q      <= '0;
            mismatch_q   <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            table_q      <= table_d;
            mismatch_q   <= mismatch_d;
            first_fail_q <= first_fail_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        table_d      = table_q;
        mismatch_d   = mismatch_q;
        first_fail_d = first_fail_q;
        vec_d        = '0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d        = '0;
                    cnt_d        = '0;
                    table_d      = '0;
                    mismatch_d   = 1'b0;
                    first_fail_d = '0;
                    busy_d       = 1'b1;
                    state_d      = DRIVE;
                end
            end
            DRIVE: begin
                vec_d  = idx_q;
                busy_d = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    table_d[idx_q] = o;
                    // First failure latches; later ones cannot displace it.
                    if ((o != EXPECTED[idx_q]) && !mismatch_q) begin
                        mismatch_d   = 1'b1;
                        first_fail_d = idx_q;
                    end
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        vec_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        vec_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {d, c, b, a} = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign truth_table  = table_q;
    assign mismatch     = mismatch_q;
    assign first_fail   = first_fail_q;

endmodule

// File: tb/tb_combo_sweep_ctrl.sv
// Directed bench for combo_sweep_ctrl: three instances (clean, mismatching
// golden table, single-cycle settle) each driving a model of o=(a&b)|(c&d).
module tb_combo_sweep_ctrl;

    logic clk;
    logic rst;
    logic start_a;
    logic start_f;

    logic        ok_a, ok_b, ok_c, ok_d, ok_busy, ok_done, ok_mis, ok_o;
    logic [15:0] ok_tbl;
    logic [3:0]  ok_ff;
    logic        bd_a, bd_b, bd_c, bd_d, bd_busy, bd_done, bd_mis, bd_o;
    logic [15:0] bd_tbl;
    logic [3:0]  bd_ff;
    logic        fs_a, fs_b, fs_c, fs_d, fs_busy, fs_done, fs_mis, fs_o;
    logic [15:0] fs_tbl;
    logic [3:0]  fs_ff;

    int n_vec;
    int n_err;

    assign ok_o = (ok_a & ok_b) | (ok_c & ok_d);
    assign bd_o = (bd_a & bd_b) | (bd_c & bd_d);
    assign fs_o = (fs_a & fs_b) | (fs_c & fs_d);

    combo_sweep_ctrl #(.SETTLE(2), .EXPECTED(16'hF888)) u_ok (
        .clk(clk), .rst(rst), .start(start_a), .o(ok_o),
        .a(ok_a), .b(ok_b), .c(ok_c), .d(ok_d),
        .busy(ok_busy), .done(ok_done), .truth_table(ok_tbl),
        .mismatch(ok_mis), .first_fail(ok_ff)
    );

    combo_sweep_ctrl #(.SETTLE(2), .EXPECTED(16'hF880)) u_bad (
        .clk(clk), .rst(rst), .start(start_a), .o(bd_o),
        .a(bd_a), .b(bd_b), .c(bd_c), .d(bd_d),
        .busy(bd_busy), .done(bd_done), .truth_table(bd_tbl),
        .mismatch(bd_mis), .first_fail(bd_ff)
    );

    combo_sweep_ctrl #(.SETTLE(1), .EXPECTED(16'hF888)) u_fast (
        .clk(clk), .rst(rst), .start(start_f), .o(fs_o),
        .a(fs_a), .b(fs_b), .c(fs_c), .d(fs_d),
        .busy(fs_busy), .done(fs_done), .truth_table(fs_tbl),
        .mismatch(fs_mis), .first_fail(fs_ff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ok_reset(input string tag);
        check({tag, "_vec"},  32'({ok_d, ok_c, ok_b, ok_a}), 32'd0);
        check({tag, "_busy"}, 32'(ok_busy), 32'd0);
        check({tag, "_done"}, 32'(ok_done), 32'd0);
        check({tag, "_tbl"},  32'(ok_tbl),  32'd0);
        check({tag, "_mis"},  32'(ok_mis),  32'd0);
        check({tag, "_ff"},   32'(ok_ff),   32'd0);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        start_a = 1'b1;
        start_f = 1'b1;

        // Reset held 3 cycles with start high.
        for (int i = 0; i < 3; i++) begin
            step();
            check_ok_reset("rst");
        end
        rst     = 1'b0;
        start_a = 1'b0;
        start_f = 1'b0;
        step();
        check("idle_busy", 32'(ok_busy), 32'd0);

        // Clean, mismatching and fast sweeps launched together; j = edge index.
        start_a = 1'b1;
        start_f = 1'b1;
        for (int j = 0; j <= 33; j++) begin
            step();
            if (j == 0) begin
                start_a = 1'b0;
                start_f = 1'b0;
            end
            check("ok_vec",  32'({ok_d, ok_c, ok_b, ok_a}), (j < 32) ? 32'(j / 2) : 32'd0);
            check("ok_busy", 32'(ok_busy), (j < 32) ? 32'd1 : 32'd0);
            check("ok_done", 32'(ok_done), (j == 32) ? 32'd1 : 32'd0);
            check("fs_vec",  32'({fs_d, fs_c, fs_b, fs_a}), (j < 16) ? 32'(j) : 32'd0);
            check("fs_busy", 32'(fs_busy), (j < 16) ? 32'd1 : 32'd0);
            check("fs_done", 32'(fs_done), (j == 16) ? 32'd1 : 32'd0);
        end
        check("ok_tbl",  32'(ok_tbl), 32'h0000_F888);
        check("ok_mis",  32'(ok_mis), 32'd0);
        check("ok_ff",   32'(ok_ff),  32'd0);
        check("bd_tbl",  32'(bd_tbl), 32'h0000_F888);
        check("bd_mis",  32'(bd_mis), 32'd1);
        check("bd_ff",   32'(bd_ff),  32'd3);
        check("fs_tbl",  32'(fs_tbl), 32'h0000_F888);
        check("fs_mis",  32'(fs_mis), 32'd0);
        check("fs_ff",   32'(fs_ff),  32'd0);

        // Start during DRIVE (edge 5) and DONE (edge 33) ignored; edge 34 accepted.
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int j = 1; j <= 34; j++) begin
            start_a = (j == 5 || j == 33 || j == 34);
            step();
            if (j == 5)  check("ign_vec5", 32'({ok_d, ok_c, ok_b, ok_a}), 32'd2);
            if (j == 6)  check("ign_vec6", 32'({ok_d, ok_c, ok_b, ok_a}), 32'd3);
            if (j == 32) check("ign_done", 32'(ok_done), 32'd1);
            if (j == 33) begin
                check("dn_busy", 32'(ok_busy), 32'd0);
                check("dn_done", 32'(ok_done), 32'd0);
                check("dn_tbl",  32'(ok_tbl),  32'h0000_F888);
                check("dn_ff",   32'(bd_ff),   32'd3);
            end
            if (j == 34) begin
                check("acc_busy", 32'(ok_busy), 32'd1);
                check("acc_tbl",  32'(ok_tbl),  32'd0);
                check("acc_mis",  32'(bd_mis),  32'd0);
            end
        end
        start_a = 1'b0;

        // Reset at edge 10 of the sweep started at edge 34, restart at edge 12.
        for (int j = 1; j <= 12; j++) begin
            rst     = (j == 10);
            start_a = (j == 12);
            step();
            check("ab_done", 32'(ok_done), 32'd0);
            if (j < 10) check("ab_vec", 32'({ok_d, ok_c, ok_b, ok_a}), 32'(j / 2));
            if (j == 10) check_ok_reset("mid_rst");
        end
        rst     = 1'b0;
        start_a = 1'b0;
        for (int j = 13; j <= 45; j++) begin
            step();
            check("rs_done", 32'(ok_done), (j == 44) ? 32'd1 : 32'd0);
            if (j < 44) check("rs_vec", 32'({ok_d, ok_c, ok_b, ok_a}), 32'((j - 12) / 2));
            if (j == 44) begin
                check("rs_busy", 32'(ok_busy), 32'd0);
                check("rs_tbl",  32'(ok_tbl),  32'h0000_F888);
                check("rs_mis",  32'(ok_mis),  32'd0);
                check("rs_bmis", 32'(bd_mis),  32'd1);
                check("rs_bff",  32'(bd_ff),   32'd3);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/combo_sweep_ctrl.md
# combo_sweep_ctrl

Sequencer that drives the 4-input combinational `combo` block through all 16 input vectors, {d,c,b,a} = 0..15. Each vector is held for a programmable settle time. The controller samples `o` for each vector into a 16-bit truth-table register and compares it on the fly against a golden table. It sits between a host/test controller (`start`/`done` handshake) and the `combo` instance, giving an on-chip self-test of the combinational datapath.

## Interface
- `SETTLE`, default 2: cycles each vector is held before `o` is sampled; legal range 1..255.
- `EXPECTED`, default 16'h0000: golden truth table; bit k = expected `o` for {d,c,b,a} = k.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: sweep request; honoured only in IDLE.
- `o` input 1: output of the `combo` instance.
- `a`, `b`, `c`, `d` outputs 1 each: registered drive to the `combo` inputs. `a` is the LSB of the index, `d` is the MSB.
- `busy` output 1: high from the cycle after `start` is accepted until `done`.
- `done` output 1: single-cycle pulse when the sweep completes.
- `table` output 16: captured truth table; bit k = sampled `o` for index k.
- `mismatch` output 1: sticky; set on any sampled bit ≠ `EXPECTED[k]`.
- `first_fail` output 4: lowest index that mismatched; 0 if none.

## Operation
- States are IDLE, DRIVE and DONE. There is a 4-bit vector index `idx` and a settle counter `cnt` sized for SETTLE-1.
- IDLE:
  - Outputs: {d,c,b,a}=0, busy=0.
  - On `start`=1: idx←0, cnt←0, table←0, mismatch←0, first_fail←0, then go to DRIVE.
- DRIVE:
  - Outputs: {d,c,b,a}=idx, busy=1.
  - Each cycle, cnt increments.
  - When cnt==SETTLE-1:
    - table[idx]←o.
    - If o≠EXPECTED[idx] and mismatch==0: mismatch←1, first_fail←idx.
    - cnt←0.
    - If idx==15, go to DONE; otherwise idx←idx+1.
- DONE:
  - Outputs: done=1, busy=0, {d,c,b,a}=0.
  - Unconditionally go to IDLE on the next edge.
- `start` in DRIVE or DONE is ignored; it is not queued.
- `table`, `mismatch` and `first_fail` hold their values after `done` until the next accepted `start` clears them.
- Once `mismatch` is set it does not change for the rest of the sweep. `first_fail` therefore always records the lowest failing index, because indices ascend.
- `o` is treated as purely combinational from {d,c,b,a}. No synchronizer is required.

## Timing
- Reset values:
  - state=IDLE.
  - a=b=c=d=0, busy=0, done=0.
  - table=16'h0000, mismatch=0, first_fail=0.
  - idx=0, cnt=0.
- Reset during DRIVE or DONE aborts the sweep on that edge with all reset values. No `done` pulse is produced for the aborted sweep.
- `rst` has priority over `start` in the same cycle.
- Timing is measured from edge 0, the edge that samples `start`=1 in IDLE:
  - Vector k is driven in cycles k·SETTLE+1 … (k+1)·SETTLE.
  - `o` for vector k is sampled at edge (k+1)·SETTLE.
  - `done`=1 for exactly one cycle, between edges 16·SETTLE and 16·SETTLE+1.
- Back-to-back operation: the earliest next `start` is accepted at edge 16·SETTLE+2. Sweep period is 16·SETTLE+2 cycles.

## Test plan
- **Reset values:** assert `rst` for 3 cycles with `start`=1 → all outputs hold reset values; busy stays 0.
- **Clean sweep:**
  - Setup: SETTLE=2, EXPECTED=16'hF888; `o`=(a&b)|(c&d) from the bench model.
  - Stimulus: pulse `start`.
  - Required response: {d,c,b,a} steps 0..15 with each value held 2 cycles; done pulses at cycle 33; table=16'hF888, mismatch=0, first_fail=0.
- **Mismatch detection:** same setup with EXPECTED=16'hF880 → table=16'hF888, mismatch=1, first_fail=3.
- **Fast sweep:** SETTLE=1 → each vector held 1 cycle; done at cycle 17; table matches the model.
- **Start during sweep:**
  - Stimulus: assert `start` at cycles 5 and 33 (SETTLE=2).
  - Required response: the cycle-5 start is ignored; the cycle-33 (DONE) start is ignored; a new start at cycle 34 is accepted, with table cleared at edge 34.
- **Reset mid-sweep:**
  - Stimulus: `rst` at cycle 10 (SETTLE=2), then `start` at cycle 12.
  - Required response: outputs return to reset values at edge 10; no `done` pulse for the aborted sweep; the new sweep completes with done at cycle 12+33=45 and the correct table.
